// File: rtl/rf_writeback_ctrl.sv
// rtl/rf_writeback_ctrl.sv - write-back merge of ALU and load-return results into the register file
// ALU has priority; deferred load returns wait in a small FIFO; scoreboard tracks outstanding loads.
module rf_writeback_ctrl #(
  parameter int LQ_DEPTH = 2,
  parameter int XLEN     = 32
) (
  input  logic            CLK,
  input  logic            RSTN,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            ld_issue,
  input  logic [4:0]      ld_issue_rd,
  input  logic            ld_valid,
  input  logic [4:0]      ld_rd,
  input  logic [XLEN-1:0] ld_data,
  output logic            ld_ready,
  output logic [30:0]     x_wen,
  output logic [XLEN-1:0] x_wdata,
  output logic [31:0]     rd_busy,
  output logic            lq_overflow
);

  localparam int PW = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
  localparam int CW = $clog2(LQ_DEPTH + 1);

  logic [XLEN-1:0] lq_data [LQ_DEPTH];
  logic [4:0]      lq_rd   [LQ_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;

  logic            accept, enq, deq;
  logic            sel_valid, sel_load;
  logic [4:0]      sel_rd;
  logic [XLEN-1:0] sel_data;
  logic [31:0]     set_mask, clr_mask, busy_d, wen_dec;
  logic            wb_valid;
  logic [4:0]      wb_rd;

  assign ld_ready = (count < CW'(LQ_DEPTH));
  assign accept   = ld_valid && ld_ready;

  always_comb begin
    sel_valid = 1'b0;
    sel_load  = 1'b0;
    sel_rd    = 5'd0;
    sel_data  = '0;
    deq       = 1'b0;
    enq       = 1'b0;
    if (alu_valid) begin
      sel_valid = 1'b1;
      sel_rd    = alu_rd;
      sel_data  = alu_data;
      enq       = accept;
    end else if (count != '0) begin
      sel_valid = 1'b1;
      sel_load  = 1'b1;
      sel_rd    = lq_rd[rd_ptr];
      sel_data  = lq_data[rd_ptr];
      deq       = 1'b1;
      enq       = accept;
    end else if (accept) begin
      // FIFO empty and ALU idle: the returning load bypasses the queue
      sel_valid = 1'b1;
      sel_load  = 1'b1;
      sel_rd    = ld_rd;
      sel_data  = ld_data;
    end
  end

  always_comb begin
    set_mask = ld_issue ? (32'd1 << ld_issue_rd) : 32'd0;
    clr_mask = sel_load ? (32'd1 << sel_rd) : 32'd0;
    busy_d   = ((rd_busy & ~clr_mask) | set_mask) & ~32'd1;
    wen_dec  = 32'd1 << wb_rd;
    x_wen    = wb_valid ? wen_dec[31:1] : 31'd0;
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      wb_valid    <= 1'b0;
      wb_rd       <= 5'd0;
      x_wdata     <= '0;
      rd_busy     <= 32'd0;
      lq_overflow <= 1'b0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (deq) rd_ptr <= rd_ptr + 1'b1;
      case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // rd=0 consumes the slot but never raises an enable or changes the data bus
      wb_valid <= sel_valid && (sel_rd != 5'd0);
      wb_rd    <= sel_rd;
      if (sel_valid && (sel_rd != 5'd0)) x_wdata <= sel_data;
      rd_busy <= busy_d;
      if (ld_valid && !ld_ready) lq_overflow <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (enq) begin
      lq_data[wr_ptr] <= ld_data;
      lq_rd[wr_ptr]   <= ld_rd;
    end
  end

endmodule

// File: tb/tb_rf_writeback_ctrl.sv
// tb/tb_rf_writeback_ctrl.sv - directed and random checks of rf_writeback_ctrl against a queue model
module tb_rf_writeback_ctrl;
  localparam int LQ_DEPTH = 2;
  localparam int XLEN = 32;

  logic            CLK = 1'b0;
  logic            RSTN;
  logic            alu_valid, ld_issue, ld_valid;
  logic [4:0]      alu_rd, ld_issue_rd, ld_rd;
  logic [XLEN-1:0] alu_data, ld_data;
  logic            ld_ready, lq_overflow;
  logic [30:0]     x_wen;
  logic [XLEN-1:0] x_wdata;
  logic [31:0]     rd_busy;

  int errors = 0;
  int checks = 0;

  typedef struct { logic [4:0] rd; logic [XLEN-1:0] data; } ld_t;
  ld_t             m_q[$];
  logic [31:0]     m_busy;
  logic [30:0]     m_wen;
  logic [XLEN-1:0] m_wdata;
  logic            m_ovf;

  rf_writeback_ctrl #(.LQ_DEPTH(LQ_DEPTH), .XLEN(XLEN)) dut (
    .CLK(CLK), .RSTN(RSTN),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_issue(ld_issue), .ld_issue_rd(ld_issue_rd),
    .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data),
    .ld_ready(ld_ready), .x_wen(x_wen), .x_wdata(x_wdata),
    .rd_busy(rd_busy), .lq_overflow(lq_overflow)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    ld_issue = 0; ld_issue_rd = 0;
    ld_valid = 0; ld_rd = 0; ld_data = 0;
  endtask

  task automatic model_reset();
    m_q.delete();
    m_busy = 0; m_wen = 0; m_wdata = 0; m_ovf = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".x_wen"}, 64'(x_wen), 64'(m_wen));
    chk({tag, ".x_wdata"}, 64'(x_wdata), 64'(m_wdata));
    chk({tag, ".rd_busy"}, 64'(rd_busy), 64'(m_busy));
    chk({tag, ".ld_ready"}, 64'(ld_ready), 64'(m_q.size() < LQ_DEPTH));
    chk({tag, ".lq_overflow"}, 64'(lq_overflow), 64'(m_ovf));
  endtask

  // One clock with current inputs; the model predicts what the outputs show after the edge.
  task automatic step(input string tag);
    bit   rdy, acc, have, is_load;
    ld_t  w, inc;
    rdy = (m_q.size() < LQ_DEPTH);
    acc = ld_valid && rdy;
    inc.rd = ld_rd; inc.data = ld_data;
    have = 0; is_load = 0;
    chk({tag, ".ready_pre"}, 64'(ld_ready), 64'(rdy));
    if (alu_valid) begin
      have = 1; w.rd = alu_rd; w.data = alu_data;
      if (acc) m_q.push_back(inc);
    end else if (m_q.size() > 0) begin
      have = 1; is_load = 1; w = m_q.pop_front();
      if (acc) m_q.push_back(inc);
    end else if (acc) begin
      have = 1; is_load = 1; w = inc;
    end
    if (ld_valid && !rdy) m_ovf = 1;
    if (is_load) m_busy[w.rd] = 0;
    if (ld_issue) m_busy[ld_issue_rd] = 1;
    m_busy[0] = 0;
    m_wen = 0;
    if (have && w.rd != 0) begin
      m_wen[w.rd - 1] = 1;
      m_wdata = w.data;
    end
    @(posedge CLK); #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    RSTN = 0; idle();
    #1;
    model_reset();
    check_all("reset");
    @(posedge CLK); #1;
    RSTN = 1;
  endtask

  initial begin
    RSTN = 1; idle(); model_reset();
    #2;
    do_reset();

    // ALU write to x5
    alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
    step("alu5");
    chk("alu5.wen_const", 64'(x_wen), 64'h10);
    chk("alu5.data_const", 64'(x_wdata), 64'hDEADBEEF);
    idle(); step("alu5_after");
    chk("alu5.wen_clear", 64'(x_wen), 64'h0);

    // load issue to x7, return three cycles later via bypass
    ld_issue = 1; ld_issue_rd = 7; step("iss7");
    chk("iss7.busy_const", 64'(rd_busy[7]), 64'h1);
    idle(); step("wait1"); step("wait2");
    ld_valid = 1; ld_rd = 7; ld_data = 32'h1234; step("ret7");
    chk("ret7.wen_const", 64'(x_wen), 64'h40);
    chk("ret7.data_const", 64'(x_wdata), 64'h1234);
    chk("ret7.busy_const", 64'(rd_busy[7]), 64'h0);
    idle();

    // rd = 0 on both sources
    alu_valid = 1; alu_rd = 0; alu_data = 32'hFFFFFFFF;
    ld_issue = 1; ld_issue_rd = 0; step("rd0");
    chk("rd0.wen_const", 64'(x_wen), 64'h0);
    chk("rd0.busy_const", 64'(rd_busy), 64'h0);
    idle(); step("rd0_after");

    // ALU saturating while loads to x10, x11 return and queue
    ld_issue = 1; ld_issue_rd = 10; step("iss10");
    ld_issue_rd = 11; step("iss11");
    idle();
    for (int i = 1; i <= 4; i++) begin
      alu_valid = 1; alu_rd = 5'(i); alu_data = 32'hA000 + i;
      ld_valid = (i <= 2); ld_rd = (i == 1) ? 5'd10 : 5'd11; ld_data = 32'hB000 + i;
      step($sformatf("sat%0d", i));
    end
    chk("sat.ready_const", 64'(ld_ready), 64'h0);
    idle(); step("drain10");
    chk("drain10.wen_const", 64'(x_wen), 64'(31'd1 << 9));
    step("drain11");
    chk("drain11.wen_const", 64'(x_wen), 64'(31'd1 << 10));
    step("drain_done");

    // overflow: fill the queue under ALU pressure, then one more return
    for (int i = 0; i < 3; i++) begin
      alu_valid = 1; alu_rd = 5'd20; alu_data = 32'hC0 + i;
      ld_valid = 1; ld_rd = 5'(21 + i); ld_data = 32'hD0 + i;
      step($sformatf("ovf%0d", i));
    end
    chk("ovf.flag_const", 64'(lq_overflow), 64'h1);
    idle();
    for (int i = 0; i < 4; i++) step("ovf_sticky");
    chk("ovf.still_set", 64'(lq_overflow), 64'h1);
    do_reset();

    // randomized traffic against the queue model
    for (int n = 0; n < 400; n++) begin
      logic [4:0] r;
      idle();
      alu_valid = ($urandom_range(0, 99) < 50);
      alu_rd = 5'($urandom); alu_data = $urandom;
      ld_valid = ($urandom_range(0, 99) < 45);
      ld_rd = 5'($urandom); ld_data = $urandom;
      r = 5'($urandom);
      if (!m_busy[r] && $urandom_range(0, 99) < 35) begin
        ld_issue = 1; ld_issue_rd = r;
      end
      step("rand");
    end
    idle();
    do_reset();

    // reset pulsed mid-drain
    for (int i = 0; i < 2; i++) begin
      ld_issue = 1; ld_issue_rd = 5'(12 + i); step("mid_iss");
    end
    idle();
    for (int i = 0; i < 2; i++) begin
      alu_valid = 1; alu_rd = 5'd3; alu_data = 32'h55;
      ld_valid = 1; ld_rd = 5'(12 + i); ld_data = 32'h66 + i;
      step("mid_fill");
    end
    idle(); step("mid_drain1");
    RSTN = 0; #1;
    model_reset();
    chk("midrst.wen", 64'(x_wen), 64'h0);
    chk("midrst.busy", 64'(rd_busy), 64'h0);
    chk("midrst.ready", 64'(ld_ready), 64'h1);
    @(posedge CLK); #1;
    RSTN = 1;
    for (int i = 0; i < 3; i++) step("post_rst");
    chk("post_rst.no_stale", 64'(x_wen), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
